// File: rtl/rec_seq_pkg.sv
// Shared types and header helpers for the recording sequencer.
// Optional channel-skip build: define REC_CH_SKIP_EN.
package rec_seq_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    localparam logic HDR_START = 1'b1;

    // Header is {start, imp_en, ch_idx, discharge}
    function automatic int hdr_w(input int ch_w);
        return ch_w + 3;
    endfunction

endpackage

// File: rtl/rec_next_ch.sv
// Wrapping ascending search for the next enabled channel after the current one.
// Only built when REC_CH_SKIP_EN is defined.
`ifdef REC_CH_SKIP_EN
module rec_next_ch #(
    parameter int NUM_CH = 32,
    localparam int CH_W = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] en_i,
    input  logic [CH_W-1:0]   cur_i,
    output logic [CH_W-1:0]   next_o,
    output logic              valid_o
);

    // Offset NUM_CH wraps back onto cur_i, so a lone enabled channel selects itself
    always_comb begin
        logic [CH_W-1:0] idx_v;
        next_o  = cur_i;
        valid_o = 1'b0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx_v = cur_i + CH_W'(k);
            if (!valid_o && en_i[idx_v]) begin
                valid_o = 1'b1;
                next_o  = idx_v;
            end else begin
                valid_o = valid_o;
            end
        end
    end

endmodule
`endif

// File: rtl/rec_seq_ctrl.sv
// Recording sequencer: channel slot timing, per-group header serialiser and discharge pulse.
// Define REC_CH_SKIP_EN to skip channels that are disabled in every group.
module rec_seq_ctrl
    import rec_seq_pkg::*;
#(
    parameter int NUM_CH     = 32,
    parameter int NUM_ADC    = 2,
    parameter int NUM_STIM   = 8,
    parameter int SLOT_LEN   = 34,
    parameter int SAMPLE_LEN = 16,
    parameter int INIT_DLY   = 31,
    parameter int PW_W       = 20,
    localparam int CH_W = $clog2(NUM_CH)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      rec_en_i,
    input  logic [NUM_ADC*NUM_CH-1:0] ch_en_i,
    input  logic [NUM_ADC*NUM_CH-1:0] imp_en_i,
    input  logic [NUM_STIM-1:0]       stim_mask_i,
    input  logic [PW_W-1:0]           pw_discharge_i,
    input  logic [NUM_ADC-1:0]        adc_res_i,
    output logic                      adc_en_o,
    output logic                      sample_out_o,
    output logic [NUM_ADC-1:0]        rec_data_o,
    output logic [CH_W-1:0]           ch_idx_o,
    output logic                      frame_o,
    output logic                      discharge_o
);

    localparam int HW      = hdr_w(CH_W);
    localparam int SLOT_CW = $clog2(SLOT_LEN);
    localparam int INIT_CW = (INIT_DLY > 1) ? $clog2(INIT_DLY) : 1;

    state_e                         state_q, state_d;
    logic [INIT_CW-1:0]             init_cnt_q, init_cnt_d;
    logic [SLOT_CW-1:0]             slot_cnt_q, slot_cnt_d;
    logic [CH_W-1:0]                ch_idx_q, ch_idx_d, adv_idx_s;
    logic [NUM_ADC-1:0][HW-1:0]     hdr_q, hdr_d;
    logic [NUM_ADC-1:0]             hdr_bit_q, hdr_bit_d, sel_q, sel_d, grp_act_s;
    logic [NUM_ADC-1:0][NUM_CH-1:0] ch_en_grp_s, imp_grp_s;
    logic                           adc_en_q, adc_en_d;
    logic [PW_W-1:0]                fcnt_q, fcnt_d, fcnt_inc_s;
    logic                           stim_or_q, stim_fall_s;
    logic [1:0]                     tail_q, tail_d;
    logic [NUM_ADC*NUM_CH-1:0]      ch_en_q;
    logic                           add_q, add_d;
    logic                           dis_q, dis_d;
    logic                           run_s, wrap_s, frame_s;

    assign ch_en_grp_s  = ch_en_i;
    assign imp_grp_s    = imp_en_i;
    assign run_s        = (state_q == ST_RUN);
    assign wrap_s       = run_s && (slot_cnt_q == SLOT_CW'(SLOT_LEN - 1));
    assign sample_out_o = run_s && (slot_cnt_q < SLOT_CW'(SAMPLE_LEN));
    assign stim_fall_s  = stim_or_q & ~(|stim_mask_i);
    assign fcnt_inc_s   = (fcnt_q == pw_discharge_i) ? {PW_W{1'b0}} : fcnt_q + PW_W'(1);

`ifdef REC_CH_SKIP_EN
    logic [NUM_CH-1:0] en_any_s;
    logic [CH_W-1:0]   nxt_s;
    logic              nxt_vld_s;

    // Channel is a candidate if any group has it enabled
    always_comb begin
        en_any_s = {NUM_CH{1'b0}};
        for (int g = 0; g < NUM_ADC; g++) begin
            en_any_s = en_any_s | ch_en_grp_s[g];
        end
    end

    rec_next_ch #(.NUM_CH(NUM_CH)) u_next_ch (
        .en_i    (en_any_s),
        .cur_i   (ch_idx_q),
        .next_o  (nxt_s),
        .valid_o (nxt_vld_s)
    );

    assign adv_idx_s = nxt_vld_s ? nxt_s : ch_idx_q;
    assign frame_s   = wrap_s && nxt_vld_s && (nxt_s <= ch_idx_q);
`else
    assign adv_idx_s = ch_idx_q + CH_W'(1);
    assign frame_s   = wrap_s && (ch_idx_q == CH_W'(NUM_CH - 1));
`endif

    // Group activity for the channel currently being slotted
    always_comb begin
        for (int g = 0; g < NUM_ADC; g++) begin
            grp_act_s[g] = ch_en_grp_s[g][ch_idx_q];
        end
    end

    // Sequencer state, slot timing and per-group header shifters
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        slot_cnt_d = slot_cnt_q;
        ch_idx_d   = ch_idx_q;
        hdr_d      = hdr_q;
        sel_d      = sel_q;
        adc_en_d   = 1'b0;
        add_d      = 1'b0;
        for (int g = 0; g < NUM_ADC; g++) begin
            hdr_bit_d[g] = hdr_q[g][HW-1];
        end
        case (state_q)
            ST_INIT: begin
                if (init_cnt_q == INIT_CW'(INIT_DLY - 1)) begin
                    state_d    = ST_IDLE;
                    init_cnt_d = {INIT_CW{1'b0}};
                end else begin
                    init_cnt_d = init_cnt_q + INIT_CW'(1);
                end
            end
            ST_IDLE: begin
                slot_cnt_d = {SLOT_CW{1'b0}};
                ch_idx_d   = {CH_W{1'b0}};
                hdr_d      = {(NUM_ADC*HW){1'b0}};
                sel_d      = {NUM_ADC{1'b0}};
                if (rec_en_i) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!rec_en_i) begin
                    state_d    = ST_IDLE;
                    slot_cnt_d = {SLOT_CW{1'b0}};
                    ch_idx_d   = {CH_W{1'b0}};
                    hdr_d      = {(NUM_ADC*HW){1'b0}};
                    sel_d      = {NUM_ADC{1'b0}};
                end else begin
                    if (wrap_s) begin
                        slot_cnt_d = {SLOT_CW{1'b0}};
                        ch_idx_d   = adv_idx_s;
                    end else begin
                        slot_cnt_d = slot_cnt_q + SLOT_CW'(1);
                    end
                    adc_en_d = (slot_cnt_q <= SLOT_CW'(SAMPLE_LEN)) && (|grp_act_s);
                    add_d    = |(ch_en_i & ~ch_en_q);
                    // Inactive groups keep the header path selected with an all-zero header
                    for (int g = 0; g < NUM_ADC; g++) begin
                        sel_d[g] = sample_out_o || !grp_act_s[g];
                        if (slot_cnt_q == {SLOT_CW{1'b0}}) begin
                            hdr_d[g] = grp_act_s[g] ?
                                {HDR_START, imp_grp_s[g][ch_idx_q], ch_idx_q, dis_q} : {HW{1'b0}};
                        end else if (slot_cnt_q <= SLOT_CW'(HW)) begin
                            hdr_d[g] = {hdr_q[g][HW-2:0], 1'b0};
                        end else begin
                            hdr_d[g] = hdr_q[g];
                        end
                    end
                end
            end
            default: begin
                state_d    = ST_INIT;
                init_cnt_d = {INIT_CW{1'b0}};
            end
        endcase
    end

    // Frame counter preset so the first frame of a recording discharges
    always_comb begin
        if (!run_s) begin
            fcnt_d = pw_discharge_i - PW_W'(1);
        end else if (frame_s) begin
            fcnt_d = fcnt_inc_s;
        end else begin
            fcnt_d = fcnt_q;
        end
        tail_d = {tail_q[0], stim_fall_s};
        dis_d  = (frame_s && (fcnt_inc_s == pw_discharge_i)) || tail_q[1] || add_q;
    end

    // State and output registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_INIT;
            init_cnt_q <= {INIT_CW{1'b0}};
            slot_cnt_q <= {SLOT_CW{1'b0}};
            ch_idx_q   <= {CH_W{1'b0}};
            hdr_q      <= {(NUM_ADC*HW){1'b0}};
            hdr_bit_q  <= {NUM_ADC{1'b0}};
            sel_q      <= {NUM_ADC{1'b0}};
            adc_en_q   <= 1'b0;
            fcnt_q     <= {PW_W{1'b0}};
            stim_or_q  <= 1'b0;
            tail_q     <= 2'b00;
            ch_en_q    <= {(NUM_ADC*NUM_CH){1'b0}};
            add_q      <= 1'b0;
            dis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            slot_cnt_q <= slot_cnt_d;
            ch_idx_q   <= ch_idx_d;
            hdr_q      <= hdr_d;
            hdr_bit_q  <= hdr_bit_d;
            sel_q      <= sel_d;
            adc_en_q   <= adc_en_d;
            fcnt_q     <= fcnt_d;
            stim_or_q  <= |stim_mask_i;
            tail_q     <= tail_d;
            ch_en_q    <= ch_en_i;
            add_q      <= add_d;
            dis_q      <= dis_d;
        end
    end

    // Data lines idle high outside a recording
    always_comb begin
        for (int g = 0; g < NUM_ADC; g++) begin
            rec_data_o[g] = run_s ? (sel_q[g] ? hdr_bit_q[g] : adc_res_i[g]) : 1'b1;
        end
    end

    assign adc_en_o    = adc_en_q;
    assign ch_idx_o    = ch_idx_q;
    assign frame_o     = frame_s;
    assign discharge_o = dis_q;

endmodule

// File: tb/tb_rec_seq_ctrl.sv
// Directed bench for rec_seq_ctrl: table-driven slot check plus multi-cycle sequences.
module tb_rec_seq_ctrl;

    localparam int NUM_CH   = 32;
    localparam int NUM_ADC  = 2;
    localparam int NUM_STIM = 8;
    localparam int PW_W     = 20;
    localparam int CH_W     = 5;

    logic                      clk = 1'b0;
    logic                      reset_i;
    logic                      rec_en_i;
    logic [NUM_ADC*NUM_CH-1:0] ch_en_i;
    logic [NUM_ADC*NUM_CH-1:0] imp_en_i;
    logic [NUM_STIM-1:0]       stim_mask_i;
    logic [PW_W-1:0]           pw_discharge_i;
    logic [NUM_ADC-1:0]        adc_res_i;
    logic                      adc_en_o;
    logic                      sample_out_o;
    logic [NUM_ADC-1:0]        rec_data_o;
    logic [CH_W-1:0]           ch_idx_o;
    logic                      frame_o;
    logic                      discharge_o;

    always #5 clk = ~clk;

    rec_seq_ctrl #(
        .NUM_CH(32), .NUM_ADC(2), .NUM_STIM(8), .SLOT_LEN(34),
        .SAMPLE_LEN(16), .INIT_DLY(31), .PW_W(20)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .rec_en_i       (rec_en_i),
        .ch_en_i        (ch_en_i),
        .imp_en_i       (imp_en_i),
        .stim_mask_i    (stim_mask_i),
        .pw_discharge_i (pw_discharge_i),
        .adc_res_i      (adc_res_i),
        .adc_en_o       (adc_en_o),
        .sample_out_o   (sample_out_o),
        .rec_data_o     (rec_data_o),
        .ch_idx_o       (ch_idx_o),
        .frame_o        (frame_o),
        .discharge_o    (discharge_o)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0] adc_res;
        logic       exp_adc_en;
        logic       exp_sample;
        logic [1:0] exp_rec;
    } vec_t;

    vec_t       tbl [34];
    logic [7:0] hdr_bits;

`ifdef REC_CH_SKIP_EN
    int skip_ch [4] = '{0, 2, 9, 2};
    int skip_fr [4] = '{0, 0, 1, 0};
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        int c_rel;
        int c_run0;
        int c_frame;
        int found;

        // Slot of channel 3: group0 enabled with imp=1, group1 disabled
        hdr_bits = 8'b1100_0110;
        for (int k = 0; k < 34; k++) begin
            tbl[k].adc_res    = 2'(k);
            tbl[k].exp_sample = (k < 16);
            tbl[k].exp_adc_en = (k >= 1 && k <= 17);
            if (k >= 17) begin
                tbl[k].exp_rec = {1'b0, tbl[k].adc_res[0]};
            end else if (k >= 2 && k <= 9) begin
                tbl[k].exp_rec = {1'b0, hdr_bits[9-k]};
            end else begin
                tbl[k].exp_rec = 2'b00;
            end
        end

        reset_i        = 1'b1;
        rec_en_i       = 1'b0;
        ch_en_i        = '0;
        imp_en_i       = '0;
        stim_mask_i    = '0;
        pw_discharge_i = 20'd2;
        adc_res_i      = 2'b00;
`ifdef REC_CH_SKIP_EN
        ch_en_i[2] = 1'b1;
        ch_en_i[9] = 1'b1;
`else
        ch_en_i[3]  = 1'b1;
        ch_en_i[5]  = 1'b1;
        imp_en_i[3] = 1'b1;
`endif
        repeat (3) step();
        chk("rst_adc_en", 32'(adc_en_o), 32'd0);
        chk("rst_sample", 32'(sample_out_o), 32'd0);
        chk("rst_rec_data", 32'(rec_data_o), 32'd3);
        chk("rst_ch_idx", 32'(ch_idx_o), 32'd0);
        chk("rst_frame", 32'(frame_o), 32'd0);
        chk("rst_discharge", 32'(discharge_o), 32'd0);

        reset_i = 1'b0;
        c_rel   = cyc;
        found   = 0;
        for (int n = 0; n < 100; n++) begin
            step();
            if (sample_out_o) begin
                found = 1;
                break;
            end
            if (cyc - c_rel == 5) rec_en_i = 1'b1;
        end
        chk("first_slot_cycle", found != 0 ? 32'(cyc - c_rel) : 32'hFFFF_FFFF, 32'd32);
        c_run0 = cyc;
        chk("first_slot_ch", 32'(ch_idx_o), 32'd0);

`ifdef REC_CH_SKIP_EN
        for (int s = 0; s < 4; s++) begin
            chk($sformatf("skip%0d_ch", s), 32'(ch_idx_o), 32'(skip_ch[s]));
            repeat (5) step();
            chk($sformatf("skip%0d_adc_en", s), 32'(adc_en_o), 32'(s != 0));
            repeat (28) step();
            chk($sformatf("skip%0d_frame", s), 32'(frame_o), 32'(skip_fr[s]));
            step();
        end
`else
        repeat (34) step();
        chk("ch_advance", 32'(ch_idx_o), 32'd1);
        repeat (68) step();

        for (int k = 0; k < 34; k++) begin
            adc_res_i = tbl[k].adc_res;
            #1;
            chk($sformatf("tbl%0d_adc_en", k), 32'(adc_en_o), 32'(tbl[k].exp_adc_en));
            chk($sformatf("tbl%0d_sample", k), 32'(sample_out_o), 32'(tbl[k].exp_sample));
            chk($sformatf("tbl%0d_rec_data", k), 32'(rec_data_o), 32'(tbl[k].exp_rec));
            chk($sformatf("tbl%0d_ch_idx", k), 32'(ch_idx_o), 32'd3);
            step();
        end

        // pw_discharge=2: frames 1 and 4 discharge
        c_frame = 0;
        for (int f = 1; f <= 4; f++) begin
            for (int n = 0; n < 1200; n++) begin
                if (frame_o) break;
                step();
            end
            if (f == 1) begin
                chk("frame1_cycle", 32'(cyc - c_run0), 32'd1087);
            end else begin
                chk($sformatf("frame%0d_period", f), 32'(cyc - c_frame), 32'd1088);
            end
            c_frame = cyc;
            step();
            chk($sformatf("frame%0d_discharge", f), 32'(discharge_o), 32'(f == 1 || f == 4));
        end

        stim_mask_i = 8'h04;
        repeat (10) begin
            step();
            chk("stim_high_discharge", 32'(discharge_o), 32'd0);
        end
        stim_mask_i = 8'h00;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk($sformatf("stim_fall_d%0d", k), 32'(discharge_o), 32'(k == 3));
        end

        ch_en_i[NUM_CH+7] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("ch_add_d%0d", k), 32'(discharge_o), 32'(k == 2));
        end

        found = 0;
        for (int n = 0; n < 400; n++) begin
            step();
            if (ch_idx_o == 5'd5) begin
                found = 1;
                break;
            end
        end
        chk("reach_ch5", 32'(found), 32'd1);
        repeat (7) step();
        chk("ch5_slot7_adc_en", 32'(adc_en_o), 32'd1);
        chk("ch5_slot7_sample", 32'(sample_out_o), 32'd1);
        rec_en_i = 1'b0;
        step();
        chk("abort_adc_en", 32'(adc_en_o), 32'd0);
        chk("abort_ch_idx", 32'(ch_idx_o), 32'd0);
        chk("abort_rec_data", 32'(rec_data_o), 32'd3);
        chk("abort_sample", 32'(sample_out_o), 32'd0);
        repeat (3) step();
        chk("idle_ch_idx", 32'(ch_idx_o), 32'd0);
        chk("idle_adc_en", 32'(adc_en_o), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
